// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the trace sweeper.
//   - state_t       : sweep FSM states
//   - *_DEF         : default geometry (column width, last column, sample width, colour width)
//   - COLOR_*       : palette colour constants
//   - ch_width()    : width of a channel index for a given channel count
package vga_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int X_W_DEF     = 8;
   localparam int X_MAX_DEF   = 159;
   localparam int Y_W_DEF     = 8;
   localparam int COLOR_W_DEF = 12;

   localparam logic [11:0] COLOR_RED   = 12'hF00;
   localparam logic [11:0] COLOR_GREEN = 12'h0F0;

   // A single channel still needs a 1-bit index so the vectors stay legal.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_col_counter.sv
// vga_col_counter: column / channel position of the sweep.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : restart at column 0, channel 0
//   adv        : step to the next column (wraps at X_MAX into the next channel)
//   x, ch      : current column and channel
//   last       : final column of the final channel
module vga_col_counter
   import vga_pkg::*;
#(
   parameter int X_W    = X_W_DEF,
   parameter int X_MAX  = X_MAX_DEF,
   parameter int NUM_CH = 2,
   parameter int CH_W   = ch_width(NUM_CH)
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            adv,
   output logic [X_W-1:0]  x,
   output logic [CH_W-1:0] ch,
   output logic            last
);

   logic [X_W-1:0]  x_r;
   logic [CH_W-1:0] ch_r;
   logic            at_max_s;
   logic            last_ch_s;

   assign at_max_s  = (x_r == X_W'(X_MAX));
   assign last_ch_s = (ch_r == CH_W'(NUM_CH - 1));
   assign x         = x_r;
   assign ch        = ch_r;
   assign last      = at_max_s && last_ch_s;

   // Column/channel position; column wraps to 0 at X_MAX, never to the counter's natural limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_r  <= '0;
         ch_r <= '0;
      end else if (clr) begin
         x_r  <= '0;
         ch_r <= '0;
      end else if (adv) begin
         if (at_max_s) begin
            x_r  <= '0;
            ch_r <= last_ch_s ? ch_r : ch_r + CH_W'(1);
         end else begin
            x_r  <= x_r + X_W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_trace_sweep.sv
// vga_trace_sweep: sweeps columns 0..X_MAX per channel and emits one plot pixel per column.
//   clk, reset           : clock, asynchronous active-low reset
//   start, mode, phase   : sweep request; mode/phase latched when the request is accepted
//   adc_data             : live samples (mode 1), channel 0 in LSBs
//   rom_addr, rom_q      : external waveform ROM (mode 0), data ROM_LAT clocks after address issue
//   pix_valid/ready      : pixel handshake; pix_x/pix_y/pix_color held while stalled
//   busy, done           : sweep in progress; one-cycle end-of-frame pulse
module vga_trace_sweep
   import vga_pkg::*;
#(
   parameter int X_W     = X_W_DEF,
   parameter int X_MAX   = X_MAX_DEF,
   parameter int Y_W     = Y_W_DEF,
   parameter int NUM_CH  = 2,
   parameter int ROM_LAT = 1,
   parameter int COLOR_W = COLOR_W_DEF,
   parameter logic [NUM_CH*COLOR_W-1:0] PALETTE = {COLOR_RED, COLOR_GREEN}
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic [NUM_CH*X_W-1:0]   phase,
   input  logic [NUM_CH*Y_W-1:0]   adc_data,
   output logic [X_W-1:0]          rom_addr,
   input  logic [Y_W-1:0]          rom_q,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic [X_W-1:0]          pix_x,
   output logic [Y_W-1:0]          pix_y,
   output logic [COLOR_W-1:0]      pix_color,
   output logic                    busy,
   output logic                    done
);

   localparam int CH_W  = ch_width(NUM_CH);
   localparam int LAT_W = 2;

   state_t                  state_r, state_s;
   logic                    mode_r;
   logic [NUM_CH*X_W-1:0]   phase_r;
   logic [LAT_W-1:0]        lat_cnt_r;
   logic [X_W-1:0]          rom_addr_r;
   logic                    pix_valid_r;
   logic [X_W-1:0]          pix_x_r;
   logic [Y_W-1:0]          pix_y_r;
   logic [COLOR_W-1:0]      pix_color_r;
   logic                    busy_r;
   logic                    done_r;

   logic [X_W-1:0]          x_s;
   logic [CH_W-1:0]         ch_s;
   logic                    last_s;
   logic                    clr_s;
   logic                    adv_s;
   logic                    lat_last_s;
   logic [X_W-1:0]          phase_sel_s;
   logic [Y_W-1:0]          adc_sel_s;
   logic [COLOR_W-1:0]      color_sel_s;

   assign clr_s      = (state_r == IDLE) && start;
   assign adv_s      = (state_r == EMIT) && pix_ready;
   assign lat_last_s = (lat_cnt_r == LAT_W'(ROM_LAT));

   assign rom_addr   = rom_addr_r;
   assign pix_valid  = pix_valid_r;
   assign pix_x      = pix_x_r;
   assign pix_y      = pix_y_r;
   assign pix_color  = pix_color_r;
   assign busy       = busy_r;
   assign done       = done_r;

   vga_col_counter #(
      .X_W    (X_W),
      .X_MAX  (X_MAX),
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_col (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .adv   (adv_s),
      .x     (x_s),
      .ch    (ch_s),
      .last  (last_s)
   );

   // Per-channel selection of phase offset, live sample and palette colour.
   always_comb begin
      phase_sel_s = '0;
      adc_sel_s   = '0;
      color_sel_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_s == CH_W'(i)) begin
            phase_sel_s = phase_r[i*X_W +: X_W];
            adc_sel_s   = adc_data[i*Y_W +: Y_W];
            color_sel_s = PALETTE[i*COLOR_W +: COLOR_W];
         end else begin
            phase_sel_s = phase_sel_s;
            adc_sel_s   = adc_sel_s;
            color_sel_s = color_sel_s;
         end
      end
   end

   // Next-state logic of the sweep FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = start ? FETCH : IDLE;
         FETCH:   state_s = mode_r ? EMIT : WAIT;
         WAIT:    state_s = lat_last_s ? EMIT : WAIT;
         EMIT: begin
            if (pix_ready) begin
               state_s = last_s ? DONE : FETCH;
            end else begin
               state_s = EMIT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath: latched request, ROM address, latency count, pixel and status outputs.
   // lat_cnt starts at 1 because the address-issue clock itself counts toward ROM_LAT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_r      <= 1'b0;
         phase_r     <= '0;
         lat_cnt_r   <= '0;
         rom_addr_r  <= '0;
         pix_valid_r <= 1'b0;
         pix_x_r     <= '0;
         pix_y_r     <= '0;
         pix_color_r <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  mode_r  <= mode;
                  phase_r <= phase;
               end
            end
            FETCH: begin
               rom_addr_r  <= x_s + phase_sel_s;
               pix_x_r     <= x_s;
               pix_color_r <= color_sel_s;
               lat_cnt_r   <= LAT_W'(1);
               if (mode_r) begin
                  pix_y_r <= adc_sel_s;
               end
            end
            WAIT: begin
               lat_cnt_r <= lat_cnt_r + LAT_W'(1);
               if (lat_last_s) begin
                  pix_y_r <= rom_q;
               end
            end
            default: begin
               lat_cnt_r <= lat_cnt_r;
            end
         endcase
         pix_valid_r <= (state_s == EMIT);
         busy_r      <= (state_s == FETCH) || (state_s == WAIT) || (state_s == EMIT);
         done_r      <= (state_s == DONE);
      end
   end

endmodule

// File: tb/tb_vga_trace_sweep.sv
// Bench for vga_trace_sweep: two instances (2 channels / ROM latency 1, 1 channel / ROM latency 3)
// driven from a table of sweeps, plus a mid-sweep reset sequence. ROM model returns its address.
module tb_vga_trace_sweep;

   typedef struct {
      int          sel;      // 0: 2-channel, ROM_LAT=1   1: 1-channel, ROM_LAT=3
      bit          mode;
      logic [15:0] phase;
      logic [15:0] adc;
      bit          bp;       // random pix_ready backpressure
      bit          poke;     // stray start pulses / input changes mid-sweep and in DONE
      int          exp_n;    // pixels per sweep
      int          exp_lat;  // start cycle -> first pix_valid cycle
   } sweep_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] phase = 16'h0000;
   logic [15:0] adc = 16'h0000;
   logic        pix_ready = 1'b1;
   int          sel = 0;

   logic [7:0]  rom_addr0, rom_q0, px0, py0;
   logic [11:0] pc0;
   logic        pv0, busy0, done0;
   logic [7:0]  rom_addr1, rom_q1, px1, py1;
   logic [11:0] pc1;
   logic        pv1, busy1, done1;
   logic [7:0]  a1 = 8'd0, a2 = 8'd0;

   logic        m_valid, m_busy, m_done;
   logic [7:0]  m_x, m_y;
   logic [11:0] m_c;

   int          n_checks = 0;
   int          n_pass = 0;
   int          n_pix;
   logic [27:0] cap [320];
   sweep_t      tbl [6];

   always #5 clk = ~clk;

   vga_trace_sweep #(.NUM_CH(2), .ROM_LAT(1)) u0 (
      .clk(clk), .reset(reset), .start(start0), .mode(mode), .phase(phase), .adc_data(adc),
      .rom_addr(rom_addr0), .rom_q(rom_q0), .pix_valid(pv0), .pix_ready(pix_ready),
      .pix_x(px0), .pix_y(py0), .pix_color(pc0), .busy(busy0), .done(done0));

   vga_trace_sweep #(.NUM_CH(1), .ROM_LAT(3), .PALETTE(12'h0F0)) u1 (
      .clk(clk), .reset(reset), .start(start1), .mode(mode), .phase(phase[7:0]), .adc_data(adc[7:0]),
      .rom_addr(rom_addr1), .rom_q(rom_q1), .pix_valid(pv1), .pix_ready(pix_ready),
      .pix_x(px1), .pix_y(py1), .pix_color(pc1), .busy(busy1), .done(done1));

   // ROM models: q = address; latency 1 is visible in the address-issue cycle's successor,
   // latency 3 adds two register stages.
   assign rom_q0 = rom_addr0;
   always @(posedge clk) begin
      a1 <= rom_addr1;
      a2 <= a1;
   end
   assign rom_q1 = a2;

   assign m_valid = (sel == 1) ? pv1   : pv0;
   assign m_busy  = (sel == 1) ? busy1 : busy0;
   assign m_done  = (sel == 1) ? done1 : done0;
   assign m_x     = (sel == 1) ? px1   : px0;
   assign m_y     = (sel == 1) ? py1   : py0;
   assign m_c     = (sel == 1) ? pc1   : pc0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic set_start(input int s, input logic v);
      if (s == 1) start1 = v;
      else start0 = v;
   endtask

   task automatic run_sweep(input sweep_t v);
      int          n;
      int          first_v;
      int          done_cnt;
      int          tail;
      bit          timed_out;
      bit          stall_prev;
      logic [27:0] held;
      int          ch, x;
      logic [7:0]  ey;
      logic [11:0] ec;
      sel = v.sel; mode = v.mode; phase = v.phase; adc = v.adc;
      n_pix = 0; first_v = -1; done_cnt = 0; tail = 0; timed_out = 1'b0;
      stall_prev = 1'b0; held = '0; n = 0;
      @(negedge clk);
      pix_ready = 1'b1;
      set_start(v.sel, 1'b1);
      while (tail < 6) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            set_start(v.sel, 1'b0);
            chk("busy_after_start", m_busy, 1);
         end
         if (v.poke && n == 2) begin
            mode  = ~v.mode;
            phase = ~v.phase;
         end
         if (v.poke && n == 40) set_start(v.sel, 1'b1);
         if (v.poke && n == 41) set_start(v.sel, 1'b0);
         if (stall_prev) chk("stall_hold", {m_valid, m_x, m_y, m_c}, {1'b1, held});
         if (m_valid && first_v < 0) begin
            first_v = n;
            chk("latency", n, v.exp_lat);
         end
         if (done_cnt > 0) begin
            tail++;
            set_start(v.sel, 1'b0);
            chk("idle_after_done", {m_valid, m_busy, m_done}, 3'b000);
         end
         if (m_done) begin
            done_cnt++;
            chk("busy_drops_with_done", m_busy, 0);
            if (v.poke) set_start(v.sel, 1'b1);
         end
         pix_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_valid && pix_ready) begin
            if (n_pix < 320) cap[n_pix] = {m_x, m_y, m_c};
            n_pix++;
         end
         stall_prev = m_valid && !pix_ready;
         held = {m_x, m_y, m_c};
         if (n > 8000) begin
            timed_out = 1'b1;
            tail = 6;
         end
      end
      pix_ready = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      chk("timeout", timed_out, 0);
      chk("pixel_count", n_pix, v.exp_n);
      chk("done_pulses", done_cnt, 1);
      for (int i = 0; i < v.exp_n && i < n_pix && i < 320; i++) begin
         ch = i / 160;
         x  = i % 160;
         ey = v.mode ? v.adc[ch*8 +: 8] : 8'(x + int'(v.phase[ch*8 +: 8]));
         ec = (ch == 1) ? 12'hF00 : 12'h0F0;
         chk("pixel", cap[i], {8'(x), ey, ec});
      end
   endtask

   // Reset in the middle of a sweep at column 77; no done pulse may follow.
   task automatic reset_mid_sweep();
      bit found;
      found = 1'b0;
      sel = 0; mode = 1'b0; phase = 16'h0000; pix_ready = 1'b1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(negedge clk);
         if (pv0 && px0 == 8'd77) found = 1'b1;
      end
      chk("reach_x77", found, 1);
      reset = 1'b0;
      #1;
      chk("reset_clears_outputs", {rom_addr0, pv0, px0, py0, pc0, busy0, done0}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_done_in_reset", {pv0, busy0, done0}, 3'b000);
      end
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("no_done_after_reset", {pv0, busy0, done0}, 3'b000);
      end
   endtask

   initial begin
      tbl[0] = '{0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 320, 3};
      tbl[1] = '{1, 1'b0, 16'h00C8, 16'h0000, 1'b0, 1'b0, 160, 5};
      tbl[2] = '{0, 1'b1, 16'h0000, 16'h4020, 1'b0, 1'b0, 320, 2};
      tbl[3] = '{0, 1'b0, 16'h1005, 16'h0000, 1'b1, 1'b1, 320, 3};
      tbl[4] = '{1, 1'b1, 16'h0000, 16'h0077, 1'b1, 1'b1, 160, 2};
      tbl[5] = '{1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 160, 5};

      repeat (3) @(negedge clk);
      chk("reset_state_u0", {rom_addr0, pv0, px0, py0, pc0, busy0, done0}, 64'd0);
      chk("reset_state_u1", {rom_addr1, pv1, px1, py1, pc1, busy1, done1}, 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 6; t++) begin
         run_sweep(tbl[t]);
         if (t == 1) begin
            chk("wrap_y_x55", cap[55][19:12], 8'd255);
            chk("wrap_y_x56", cap[56][19:12], 8'd0);
         end
      end

      reset_mid_sweep();
      run_sweep(tbl[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
